// File: rtl/radix_pkg.sv
// radix_pkg: shared types for the radix memory arbiter.
//   arb_state_t - arbiter FSM states
//   req_id_t    - which requester owns the in-flight transaction
//   STREAK_W    - width of the LS-grant streak counter (holds limits 1..15)
package radix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/radix_arb_grant.sv
// radix_arb_grant: grant decision between fetch (IF) and load/store (LS)
// requesters, with a starvation guard for IF.
//   clk, rst            - clock, synchronous active-high reset
//   arb_en              - arbitration window open (arbiter idle)
//   if_valid, ls_valid  - requester valids
//   grant_if, grant_ls  - one-hot grant, combinational
module radix_arb_grant
  import radix_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  // Consecutive LS grants taken while IF was also waiting.
  logic [STREAK_W-1:0] streak;
  logic                if_starved;

  always_comb begin
    if_starved = if_valid && (streak == LIMIT);
    grant_ls   = arb_en && ls_valid && !if_starved;
    grant_if   = arb_en && if_valid && !grant_ls;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_if) begin
      streak <= '0;
    end else if (grant_ls) begin
      // An LS grant with nobody else waiting is not starving anyone.
      if (!if_valid)
        streak <= '0;
      else if (streak != LIMIT)
        streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/radix_mem_arbiter.sv
// radix_mem_arbiter: shares one memory port between an instruction-fetch (IF)
// and a load/store (LS) requester, one transaction in flight at a time.
//   clk, rst          - clock, synchronous active-high reset
//   if_req_*          - fetch request (valid/ready/addr)
//   if_rsp_*          - fetch response, one-cycle valid pulse + data
//   ls_req_*          - load/store request (valid/ready/addr/we/wdata/be)
//   ls_rsp_*          - load data or store ack, one-cycle pulse (data 0 on store)
//   mem_req_*         - memory request, held stable until mem_req_ready
//   mem_rsp_*         - memory response, one per request
//   err_spurious      - sticky flag: memory response arrived outside WAIT
//
// state | meaning
// IDLE  | arbitrate; winner sees ready and its request is latched
// ISSUE | present latched request to memory until accepted
// WAIT  | wait for the memory response, capture read data
// RESP  | one-cycle response pulse to the owning requester
module radix_mem_arbiter
  import radix_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_data,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [DATA_W-1:0]     ls_req_wdata,
  input  logic [DATA_W/8-1:0]   ls_req_be,
  output logic                  ls_rsp_valid,
  output logic [DATA_W-1:0]     ls_rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_we,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_be,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic                  err_spurious
);

  arb_state_t            state, state_nxt;
  req_id_t               owner_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  grant_if, grant_ls;
  logic                  arb_en;

  // Gating with rst keeps ready low during the reset cycle itself.
  assign arb_en = (state == IDLE) && !rst;

  radix_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_comb begin
    state_nxt     = state;
    if_req_ready  = grant_if;
    ls_req_ready  = grant_ls;
    mem_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    ls_rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_if || grant_ls)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid)
          state_nxt = RESP;
      end
      RESP: begin
        if_rsp_valid = (owner_q == REQ_IF);
        ls_rsp_valid = (owner_q == REQ_LS);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= REQ_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_ls) begin
        owner_q <= REQ_LS;
        addr_q  <= ls_req_addr;
        we_q    <= ls_req_we;
        wdata_q <= ls_req_wdata;
        be_q    <= ls_req_be;
      end else if (grant_if) begin
        owner_q <= REQ_IF;
        addr_q  <= if_req_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        be_q    <= '1;
      end
      if (mem_rsp_valid) begin
        if (state == WAIT)
          rdata_q <= we_q ? '0 : mem_rsp_data;
        else
          err_q <= 1'b1;
      end
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;
  assign if_rsp_data   = rdata_q;
  assign ls_rsp_data   = rdata_q;
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_radix_mem_arbiter.sv
// tb_radix_mem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level reference model of the arbiter.
module tb_radix_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int BE_W         = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              ls_req_valid, ls_req_ready;
  logic [ADDR_W-1:0] ls_req_addr;
  logic              ls_req_we;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [BE_W-1:0]   ls_req_be;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [BE_W-1:0]   mem_req_be;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              err_spurious;

  always #5 clk = ~clk;

  radix_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_spurious(err_spurious)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one outstanding transaction and its progress.
  bit                busy, issued, responded;
  int                rdy_cnt, rsp_cnt, lat_exp, acc_cyc, issue_cycles;
  bit                t_ls, t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata, t_rdata;
  logic [BE_W-1:0]   t_be;
  int                streak_m;
  bit                err_m;

  // Memory-side environment knobs.
  bit                auto_mem, rand_delays, fixed_data;
  int                rdy_delay_cfg, rsp_delay_cfg, spur_rate;
  logic [DATA_W-1:0] fixed_data_val;

  bit                grant_q[$];   // observed grants, 1 = LS

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at posedge+1 with requester inputs already set; checks this
  // cycle's outputs against the model, then advances to posedge+1.
  task automatic run_cycle();
    bit idle_ph, issue_ph, wait_ph, resp_ph;
    bit exp_if_rdy, exp_ls_rdy;
    idle_ph  = !busy;
    issue_ph = busy && !issued;
    wait_ph  = busy && issued && !responded;
    resp_ph  = busy && responded;
    if (auto_mem) begin
      mem_req_ready = issue_ph && (rdy_cnt == 0);
      mem_rsp_valid = wait_ph && (rsp_cnt == 0);
      mem_rsp_data  = fixed_data ? fixed_data_val : $urandom;
      if (!wait_ph && spur_rate > 0 && $urandom_range(spur_rate - 1) == 0)
        mem_rsp_valid = 1'b1;
    end
    #1;
    if (rst) begin
      busy     = 1'b0;
      streak_m = 0;
      err_m    = 1'b0;
    end else begin
      exp_if_rdy = 1'b0;
      exp_ls_rdy = 1'b0;
      if (idle_ph) begin
        if (ls_req_valid && !(if_req_valid && streak_m == STARVE_LIMIT))
          exp_ls_rdy = 1'b1;
        else if (if_req_valid)
          exp_if_rdy = 1'b1;
      end
      check_val("if_req_ready", if_req_ready, exp_if_rdy);
      check_val("ls_req_ready", ls_req_ready, exp_ls_rdy);
      if (if_req_ready)
        grant_q.push_back(1'b0);
      else if (ls_req_ready)
        grant_q.push_back(1'b1);

      check_val("mem_req_valid", mem_req_valid, issue_ph);
      if (issue_ph) begin
        check_val("mem_req_addr", mem_req_addr, t_addr);
        check_val("mem_req_we", mem_req_we, t_we);
        check_val("mem_req_wdata", mem_req_wdata, t_wdata);
        check_val("mem_req_be", mem_req_be, t_be);
        issue_cycles++;
        if (mem_req_ready) issued = 1'b1;
        else rdy_cnt--;
      end

      check_val("if_rsp_valid", if_rsp_valid, resp_ph && !t_ls);
      check_val("ls_rsp_valid", ls_rsp_valid, resp_ph && t_ls);
      if (resp_ph) begin
        check_val(t_ls ? "ls_rsp_data" : "if_rsp_data", t_ls ? ls_rsp_data : if_rsp_data, t_rdata);
        check_val("latency", cyc - acc_cyc, lat_exp);
        busy = 1'b0;
      end
      if (wait_ph) begin
        if (mem_rsp_valid) begin
          responded = 1'b1;
          t_rdata   = t_we ? '0 : mem_rsp_data;
        end else begin
          rsp_cnt--;
        end
      end

      check_val("err_spurious", err_spurious, err_m);
      if (mem_rsp_valid && !wait_ph) err_m = 1'b1;

      if (exp_if_rdy || exp_ls_rdy) begin
        busy         = 1'b1;
        issued       = 1'b0;
        responded    = 1'b0;
        acc_cyc      = cyc;
        issue_cycles = 0;
        t_ls         = exp_ls_rdy;
        if (exp_ls_rdy) begin
          t_addr   = ls_req_addr;
          t_we     = ls_req_we;
          t_wdata  = ls_req_wdata;
          t_be     = ls_req_be;
          streak_m = if_req_valid ? ((streak_m < STARVE_LIMIT) ? streak_m + 1 : STARVE_LIMIT) : 0;
        end else begin
          t_addr   = if_req_addr;
          t_we     = 1'b0;
          t_wdata  = '0;
          t_be     = '1;
          streak_m = 0;
        end
        rdy_cnt = rand_delays ? int'($urandom_range(3)) : rdy_delay_cfg;
        rsp_cnt = rand_delays ? int'($urandom_range(3)) : rsp_delay_cfg;
        lat_exp = 3 + rdy_cnt + rsp_cnt;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      run_cycle();
      k++;
    end
    check_val("txn_done", busy, 1'b0);
  endtask

  task automatic clear_reqs();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_we = 0; ls_req_wdata = '0; ls_req_be = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    busy = 0; issued = 0; responded = 0; streak_m = 0; err_m = 0;
    auto_mem = 1; rand_delays = 0; fixed_data = 0; fixed_data_val = '0;
    rdy_delay_cfg = 0; rsp_delay_cfg = 0; spur_rate = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state: every output quiet.
    check_val("rst_if_req_ready", if_req_ready, 0);
    check_val("rst_ls_req_ready", ls_req_ready, 0);
    check_val("rst_mem_req_valid", mem_req_valid, 0);
    check_val("rst_mem_req_addr", mem_req_addr, 0);
    check_val("rst_mem_req_wdata", mem_req_wdata, 0);
    check_val("rst_mem_req_be", mem_req_be, 0);
    check_val("rst_if_rsp_valid", if_rsp_valid, 0);
    check_val("rst_ls_rsp_valid", ls_rsp_valid, 0);
    check_val("rst_if_rsp_data", if_rsp_data, 0);
    check_val("rst_ls_rsp_data", ls_rsp_data, 0);
    check_val("rst_err_spurious", err_spurious, 0);

    // Fetch, zero-wait memory: pulse at N+3, all byte enables.
    fixed_data = 1; fixed_data_val = 32'hDEADBEEF;
    if_req_valid = 1; if_req_addr = 32'h100;
    run_cycle();
    clear_reqs();
    check_val("fetch_be_ones", t_be, {BE_W{1'b1}});
    wait_idle(10);

    // Store with memory back-pressure: request held four cycles, ack data 0.
    rdy_delay_cfg = 3;
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 32'h20;
    ls_req_wdata = 32'h12345678; ls_req_be = 4'h3;
    run_cycle();
    clear_reqs();
    wait_idle(15);
    check_val("store_hold_cycles", issue_cycles, 4);
    rdy_delay_cfg = 0;

    // Both requesters always valid: LS x4 then IF, repeating.
    do_reset();
    grant_q.delete();
    if_req_valid = 1; ls_req_valid = 1;
    for (int k = 0; k < 100 && grant_q.size() < 10; k++) begin
      if_req_addr = $urandom; ls_req_addr = $urandom; ls_req_wdata = $urandom;
      ls_req_we = 1'($urandom_range(1)); ls_req_be = 4'($urandom_range(15));
      run_cycle();
    end
    clear_reqs();
    wait_idle(10);
    check_val("grant_count", grant_q.size(), 10);
    for (int i = 0; i < 10 && i < grant_q.size(); i++)
      check_val("grant_order", grant_q[i], (i % 5) != 4);

    // Spurious response while idle: no pulse, sticky error until reset.
    auto_mem = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    run_cycle();
    mem_rsp_valid = 0;
    for (int k = 0; k < 3; k++) run_cycle();
    check_val("err_sticky", err_spurious, 1);
    auto_mem = 1;
    do_reset();
    check_val("err_cleared", err_spurious, 0);

    // Reset while waiting on memory, then a late response.
    rsp_delay_cfg = 6;
    if_req_valid = 1; if_req_addr = 32'h400;
    run_cycle();
    clear_reqs();
    run_cycle();
    run_cycle();
    check_val("in_wait_before_rst", issued && !responded, 1);
    rst = 1;
    run_cycle();
    rst = 0;
    auto_mem = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h0BADF00D;
    run_cycle();
    mem_rsp_valid = 0;
    run_cycle();
    check_val("late_rsp_err", err_spurious, 1);
    auto_mem = 1; rsp_delay_cfg = 0; fixed_data_val = 32'h55AA0F0F;
    if_req_valid = 1; if_req_addr = 32'h404;
    run_cycle();
    clear_reqs();
    wait_idle(10);

    // LS withdrawn a cycle before IF: IF wins, streak starts over.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      if_req_valid = 1; ls_req_valid = 1;
      run_cycle();
      clear_reqs();
      wait_idle(10);
    end
    run_cycle();
    grant_q.delete();
    if_req_valid = 1; if_req_addr = 32'h800;
    run_cycle();
    clear_reqs();
    wait_idle(10);
    check_val("withdraw_if_granted", (grant_q.size() == 1) && (grant_q[0] == 1'b0), 1);
    grant_q.delete();
    if_req_valid = 1; ls_req_valid = 1;
    for (int k = 0; k < 60 && grant_q.size() < 5; k++) run_cycle();
    clear_reqs();
    wait_idle(10);
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      check_val("post_withdraw_order", grant_q[i], i != 4);

    // Randomized traffic with random memory delays and stray responses.
    do_reset();
    fixed_data = 0; rand_delays = 1; spur_rate = 40;
    for (int k = 0; k < 3000; k++) begin
      if_req_valid = ($urandom_range(9) < 6);
      ls_req_valid = ($urandom_range(9) < 6);
      if_req_addr  = $urandom;
      ls_req_addr  = $urandom;
      ls_req_we    = 1'($urandom_range(1));
      ls_req_wdata = $urandom;
      ls_req_be    = 4'($urandom_range(15));
      rst          = ($urandom_range(399) == 0);
      run_cycle();
    end
    rst = 0;
    spur_rate = 0;
    clear_reqs();
    wait_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/radix_mem_arbiter.md
RADIX_MEM_ARBITER -- requirements
Module: radix_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive LS grants while IF waits (range 1..15).
REQ-004 SHALL have ports as follows (one clock; reset synchronous, active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch data valid, 1-cycle pulse
- if_rsp_data  out  DATA_W  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted
- ls_req_addr  in  ADDR_W  load/store address
- ls_req_we  in  1  1 = store
- ls_req_wdata  in  DATA_W  store data
- ls_req_be  in  DATA_W/8  byte enables
- ls_rsp_valid  out  1  load data / store ack, 1-cycle pulse
- ls_rsp_data  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  memory address
- mem_req_we  out  1  memory write
- mem_req_wdata  out  DATA_W  memory write data
- mem_req_be  out  DATA_W/8  memory byte enables (all ones for fetch)
- mem_rsp_valid  in  1  memory response, one per request, including writes
- mem_rsp_data  in  DATA_W  memory read data
- err_spurious  out  1  sticky: mem_rsp_valid seen outside WAIT

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; at most one memory transaction outstanding.
REQ-006 IDLE: if any request valid, SHALL assert ready to exactly one winner (combinationally), register its fields and requester id, and move to ISSUE; otherwise stay. In all other states both ready outputs SHALL be 0.
REQ-007 Arbitration SHALL prefer LS, except IF wins when both are valid and streak == STARVE_LIMIT.
REQ-008 streak SHALL increment on an LS grant made while if_req_valid=1, clear on an LS grant made while if_req_valid=0, clear on any IF grant, and saturate at STARVE_LIMIT.
REQ-009 ISSUE: mem_req_valid=1 with registered fields held stable; on mem_req_ready=1, SHALL go to WAIT.
REQ-010 WAIT: on mem_rsp_valid=1, SHALL capture mem_rsp_data (0 if store) and go to RESP.
REQ-011 RESP: SHALL pulse rsp_valid of the owning requester only, for exactly one cycle, then go to IDLE.
REQ-012 Minimum latency SHALL be 3 cycles from request accept (cycle N) to rsp_valid (N+3), with mem_req_ready and mem_rsp_valid each asserted at first opportunity.
REQ-013 mem_rsp_valid outside WAIT SHALL be ignored and SHALL set err_spurious, which remains set until rst.
REQ-014 Requester inputs are not sampled outside IDLE; valid deasserted before acceptance SHALL be legal.

Reset
REQ-015 On rst=1 at a clock edge, the FSM SHALL be in IDLE, streak 0 and err_spurious 0, and all valid/ready outputs and data outputs SHALL be 0.
REQ-016 rst mid-transaction SHALL abandon the transaction without emitting a response; a late mem_rsp_valid after rst SHALL set err_spurious.

Structure
REQ-017 radix_pkg SHALL hold the arb_state_t enum (IDLE, ISSUE, WAIT, RESP) and the req_id_t enum (REQ_IF, REQ_LS).
REQ-018 Grant decision and streak counter SHALL live in the sub-module radix_arb_grant.

Verification
REQ-019 IF only, addr 0x100, mem ready immediately, rsp 0xDEADBEEF at first WAIT cycle -> if_rsp_valid pulses at N+3 with 0xDEADBEEF; mem_req_be=all ones.
REQ-020 Both valid continuously with STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF, repeating.
REQ-021 LS store addr 0x20, wdata 0x12345678, be 0x3, mem_req_ready low 3 cycles -> mem_req fields stable for 4 cycles; ls_rsp_valid with data 0.
REQ-022 mem_rsp_valid pulsed in IDLE -> no rsp_valid; err_spurious=1 until rst.
REQ-023 rst asserted in WAIT, then mem_rsp_valid -> no rsp pulse; err_spurious=1; the next IF request completes normally.
REQ-024 LS valid withdrawn in IDLE the cycle before IF is asserted -> IF is granted; streak is cleared.
